affine_addr_checker: RTL and testbench

- Receiving end of the 2D affine address stream produced by the scan-chain address generators (x counter, y counter, stride accumulator, offset).
- Accepts an incoming address stream with valid/ready handshake and recomputes the expected address sequence from the same configuration.
- Recovers the (x, y) coordinate of each beat, flags row-last and frame-last, and reports any address that differs from the expected one.
- Sits on the memory side of a buffer port, feeding coordinates to downstream logic and error status to debug.

---
 rtl/scan_pkg.sv | 23 ++
 rtl/affine_seq_ctr.sv | 71 +++++++
 rtl/affine_addr_checker.sv | 167 ++++++++++++++++
 tb/tb_affine_addr_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and default widths for the affine address checker.
package scan_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int CFG_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // One frame's configuration, captured on start. Field widths follow the
  // package defaults, so the top-level width parameters must match them.
  typedef struct packed {
    logic [CFG_W_DEF-1:0]  x_max;
    logic [CFG_W_DEF-1:0]  y_max;
    logic [ADDR_W_DEF-1:0] x_stride;
    logic [CFG_W_DEF-1:0]  y_stride;
    logic [CFG_W_DEF-1:0]  offset;
  } cfg_t;

endpackage

// File: rtl/affine_seq_ctr.sv
// Expected-sequence generator: tracks (x, y) and the expected address for
// the next beat, and flags the row-last / frame-last positions.
module affine_seq_ctr
  import scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CFG_W  = CFG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              advance_i,
  input  cfg_t              cfg_i,
  output logic [CFG_W-1:0]  x_o,
  output logic [CFG_W-1:0]  y_o,
  output logic [ADDR_W-1:0] exp_o,
  output logic              row_last_o,
  output logic              frame_last_o
);

  logic [CFG_W-1:0]  x_q, x_d;
  logic [CFG_W-1:0]  y_q, y_d;
  logic [ADDR_W-1:0] exp_q, exp_d;

  assign row_last_o   = (x_q == cfg_i.x_max - CFG_W'(1));
  assign frame_last_o = row_last_o && (y_q == cfg_i.y_max - CFG_W'(1));

  // Next position: restart at (0,0) on load, otherwise step along the raster.
  always_comb begin
    // NOTE: every combinationally assigned variable gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    x_d   = x_q;
    y_d   = y_q;
    exp_d = exp_q;
    if (load_i) begin
      x_d   = '0;
      y_d   = '0;
      exp_d = base_i;
    end else if (advance_i) begin
      if (row_last_o) begin
        x_d   = '0;
        y_d   = y_q + CFG_W'(1);
        exp_d = exp_q + cfg_i.y_stride[ADDR_W-1:0];
      end else begin
        x_d   = x_q + CFG_W'(1);
        exp_d = exp_q + cfg_i.x_stride;
      end
    end
  end

  // Position and expected-address registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      exp_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      exp_q <= exp_d;
    end
  end

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign exp_o = exp_q;

endmodule

// File: rtl/affine_addr_checker.sv
// Checks an incoming 2D affine address stream against the sequence implied
// by its configuration, emitting (x, y), row/frame-last and an error flag per
// beat through a single full-throughput output register.
module affine_addr_checker
  import scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CFG_W  = CFG_W_DEF,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CFG_W-1:0]  x_max,
  input  logic [CFG_W-1:0]  y_max,
  input  logic [ADDR_W-1:0] x_stride,
  input  logic [CFG_W-1:0]  y_stride,
  input  logic [CFG_W-1:0]  offset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CFG_W-1:0]  out_x,
  output logic [CFG_W-1:0]  out_y,
  output logic              out_row_last,
  output logic              out_frame_last,
  output logic              out_err,
  output logic [ERR_W-1:0]  err_count,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;
  cfg_t   cfg_q, cfg_d, cfg_in;

  logic              ctr_load;
  logic              accept;
  logic              mismatch;
  logic              err_clr;
  logic [CFG_W-1:0]  ctr_x, ctr_y;
  logic [ADDR_W-1:0] ctr_exp;
  logic              ctr_row_last, ctr_frame_last;

  logic              out_valid_q, out_valid_d;
  logic [CFG_W-1:0]  out_x_q, out_x_d;
  logic [CFG_W-1:0]  out_y_q, out_y_d;
  logic              out_rl_q, out_rl_d;
  logic              out_fl_q, out_fl_d;
  logic              out_err_q, out_err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  assign cfg_in = '{x_max: x_max, y_max: y_max, x_stride: x_stride,
                    y_stride: y_stride, offset: offset};

  // Accept only in RUN while the output slot is empty or being popped.
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign mismatch = (in_addr != ctr_exp);

  affine_seq_ctr #(
    .ADDR_W (ADDR_W),
    .CFG_W  (CFG_W)
  ) u_seq_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (ctr_load),
    .base_i       (offset[ADDR_W-1:0]),
    .advance_i    (accept),
    .cfg_i        (cfg_q),
    .x_o          (ctr_x),
    .y_o          (ctr_y),
    .exp_o        (ctr_exp),
    .row_last_o   (ctr_row_last),
    .frame_last_o (ctr_frame_last)
  );

  // Frame control: launch, run until the frame-last beat, drain the output.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    ctr_load = 1'b0;
    err_clr  = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d    = cfg_in;
          ctr_load = 1'b1;
          err_clr  = 1'b1;
          state_d  = ((x_max == '0) || (y_max == '0)) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && ctr_frame_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output slot: load on accept, otherwise empty on pop, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_rl_d    = out_rl_q;
    out_fl_d    = out_fl_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_x_d     = ctr_x;
      out_y_d     = ctr_y;
      out_rl_d    = ctr_row_last;
      out_fl_d    = ctr_frame_last;
      out_err_d   = mismatch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && mismatch && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // State, configuration and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_rl_q    <= 1'b0;
      out_fl_q    <= 1'b0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_rl_q    <= out_rl_d;
      out_fl_q    <= out_fl_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_x          = out_x_q;
  assign out_y          = out_y_q;
  assign out_row_last   = out_rl_q;
  assign out_frame_last = out_fl_q;
  assign out_err        = out_err_q;
  assign err_count      = err_cnt_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_affine_addr_checker.sv
// Randomized self-checking bench for affine_addr_checker against a
// closed-form raster address model.
module tb_affine_addr_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] x_max, y_max, y_stride, offset;
  logic [15:0] x_stride;
  logic        start, in_valid, in_ready;
  logic [15:0] in_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_x, out_y;
  logic        out_row_last, out_frame_last, out_err;
  logic [15:0] err_count;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned x;
    int unsigned y;
    bit          rl;
    bit          fl;
    bit          err;
  } res_t;

  affine_addr_checker dut (
    .clk(clk), .rst_n(rst_n), .x_max(x_max), .y_max(y_max),
    .x_stride(x_stride), .y_stride(y_stride), .offset(offset),
    .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_row_last(out_row_last),
    .out_frame_last(out_frame_last), .out_err(out_err),
    .err_count(err_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Address of beat k of a raster: each full row advances the address by
  // (x_max-1)*x_stride + y_stride, each column by x_stride.
  function automatic logic [15:0] model_addr(input int unsigned k, xm, xs, ys, off);
    int unsigned x, y;
    x = k % xm;
    y = k / xm;
    return 16'(off + y * ((xm - 1) * xs + ys) + x * xs);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_out_x"}, out_x, 0);
    check({tag, "_out_y"}, out_y, 0);
    check({tag, "_flags"}, {out_row_last, out_frame_last, out_err}, 0);
  endtask

  task automatic run_frame(input int unsigned xm, ym, input logic [15:0] xs,
                           input int unsigned ys, off, input int corrupt_idx,
                           input bit rand_bp, input bit rand_err, input int abort_at);
    int unsigned total;
    int          sent, got, dones, exp_errs, cyc;
    bit          finished, held;
    logic [66:0] held_vec;
    bit          corrupt[$];
    res_t        q[$];
    res_t        e;
    logic [15:0] addr;

    total = xm * ym;
    sent = 0; got = 0; dones = 0; exp_errs = 0; cyc = 0;
    finished = 0; held = 0; held_vec = '0;
    for (int k = 0; k < int'(total); k++)
      corrupt.push_back((k == corrupt_idx) || (rand_err && $urandom_range(0, 7) == 0));

    @(negedge clk);
    x_max = xm; y_max = ym; x_stride = xs; y_stride = ys; offset = off;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Configuration changes after launch must not disturb the frame.
    x_max = $urandom; y_max = $urandom; x_stride = 16'($urandom);
    y_stride = $urandom; offset = $urandom;

    while (!finished && cyc < 2000) begin
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = rand_bp && ($urandom_range(0, 7) == 0);
      if (sent < int'(total)) begin
        in_valid = !rand_bp || ($urandom_range(0, 3) != 0);
        addr = model_addr(sent, xm, xs, ys, off);
        if (corrupt[sent]) addr = (sent == corrupt_idx) ? 16'hDEAD : addr ^ 16'(1 + $urandom_range(0, 16'hFFFE));
        if (addr == model_addr(sent, xm, xs, ys, off)) addr = ~addr;
        if (!corrupt[sent]) addr = model_addr(sent, xm, xs, ys, off);
        in_addr = addr;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_addr  = 16'($urandom);
      end
      #1;
      if (held)
        check("hold_stable", {out_x, out_y, out_row_last, out_frame_last, out_err} == held_vec, 1);
      if (out_valid && !out_ready) begin
        check("hold_in_ready", in_ready, 0);
        held = 1;
        held_vec = {out_x, out_y, out_row_last, out_frame_last, out_err};
      end else begin
        held = 0;
      end
      if (sent >= int'(total)) check("in_ready_after_frame", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("extra_result", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_x", out_x, e.x);
          check("out_y", out_y, e.y);
          check("out_row_last", out_row_last, e.rl);
          check("out_frame_last", out_frame_last, e.fl);
          check("out_err", out_err, e.err);
        end
        got++;
      end
      if (in_valid && in_ready && sent < int'(total)) begin
        e.x   = sent % xm;
        e.y   = sent / xm;
        e.rl  = (e.x == xm - 1);
        e.fl  = e.rl && (e.y == ym - 1);
        e.err = corrupt[sent];
        if (e.err) exp_errs++;
        q.push_back(e);
        sent++;
      end
      if (done) begin
        dones++;
        check("done_busy", busy, 1);
        if (total == 0) check("zero_done_latency", cyc, 0);
        finished = 1;
      end
      if (abort_at >= 0 && sent == abort_at) begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("abort");
        check("abort_no_done", dones, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("abort_idle_done", done, 0);
        check("abort_idle_busy", busy, 0);
        return;
      end
      start = 1'b0;
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end

    start = 1'b0;
    in_valid = 1'b0;
    if (!finished) check("frame_timeout", 0, 1);
    check("result_count", got, total);
    check("results_left", q.size(), 0);
    check("done_count", dones, 1);
    check("err_count", err_count, (exp_errs > 65535) ? 65535 : exp_errs);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_in_ready", in_ready, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_addr = '0;
    x_max = '0; y_max = '0; x_stride = '0; y_stride = '0; offset = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    run_frame(4, 3, 16'd1, 1, 32'h100, -1, 0, 0, -1);          // linear stream
    run_frame(4, 3, 16'd2, 32'hFFFA, 32'h100, -1, 0, 0, -1);   // 2D wrap-back
    run_frame(4, 3, 16'd1, 1, 32'h100, -1, 1, 0, -1);          // backpressure
    run_frame(4, 3, 16'd1, 1, 32'h100, 5, 0, 0, -1);           // beat 5 corrupted
    run_frame(4, 1, 16'd1, 1, 32'hFFFE, -1, 0, 0, -1);         // address wrap
    run_frame(0, 3, 16'd1, 1, 32'h100, -1, 0, 0, -1);          // x_max = 0
    run_frame(4, 0, 16'd1, 1, 32'h100, -1, 1, 0, -1);          // y_max = 0
    run_frame(4, 3, 16'd1, 1, 32'h100, 2, 0, 0, 6);            // reset mid-frame
    run_frame(4, 3, 16'd1, 1, 32'h100, -1, 1, 0, -1);          // recovery frame

    for (int i = 0; i < 8; i++)
      run_frame($urandom_range(1, 6), $urandom_range(1, 5), 16'($urandom),
                $urandom, $urandom, -1, 1, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
